// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetches over an imem handshake, then steps
// DECODE/EXEC/MEM/WB, driving the execute-stage datapath controls.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        zero,
    output logic        ir_load,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM    = 2'b10;
    localparam logic [1:0] ERR_DMEM    = 2'b11;

    localparam logic [TIMEOUT_W-1:0] TO_CNT = TIMEOUT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [1:0]           err_q, err_d;

    logic                 instr_unused;
    logic                 timeout_hit;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 is_lw, is_sw, is_beq, is_jal, is_legal;
    logic [1:0]           alu_op_dec;
    logic                 alu_src_dec;
    logic                 imem_req_fsm;

    assign instr_unused = ^instr[31:7];

    // A zero TIMEOUT never matches here, so the wait is unbounded.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);
    assign cnt_inc     = (cnt_q == {TIMEOUT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    assign is_lw    = (opcode_q == OP_LW);
    assign is_sw    = (opcode_q == OP_SW);
    assign is_beq   = (opcode_q == OP_BEQ);
    assign is_jal   = (opcode_q == OP_JAL);
    assign is_legal = (opcode_q == OP_R) || (opcode_q == OP_I) || is_lw || is_sw
                      || is_beq || is_jal;

    always_comb begin
        alu_op_dec  = 2'b00;
        alu_src_dec = 1'b0;
        case (opcode_q)
            OP_R:         alu_op_dec = 2'b10;
            OP_I:         begin alu_op_dec = 2'b10; alu_src_dec = 1'b1; end
            OP_LW, OP_SW: alu_src_dec = 1'b1;
            OP_BEQ:       alu_op_dec = 2'b01;
            default:      ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        opcode_d     = opcode_q;
        err_d        = err_q;
        imem_req_fsm = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;

        // ALU controls stay valid past EXEC so address/result remain stable.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op  = alu_op_dec;
            alu_src = alu_src_dec;
        end

        case (state_q)
            S_FETCH: begin
                imem_req_fsm = 1'b1;
                if (imem_ack) begin
                    opcode_d = instr[6:0];
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    err_d   = ERR_IMEM;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_en   = 1'b1;
                    pc_sel  = zero ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    err_d   = ERR_DMEM;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                pc_en   = 1'b1;
                pc_sel  = is_jal ? 2'b10 : 2'b00;
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // Request is held off while reset is asserted so it first rises after release.
    assign imem_req = imem_req_fsm & reset;
    assign ir_load  = imem_req & imem_ack;
    assign state    = state_q;
    assign halted   = (state_q == S_HALT);
    assign err_code = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            opcode_q <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle stimulus and expected outputs
// are queued together, then replayed and compared one cycle at a time.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_load;
        logic       dmem_req;
        logic       dmem_we;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       halted;
        logic [1:0] err_code;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        ia;
        logic        da;
        logic        z;
        logic [31:0] ins;
        exp_t        e;
    } step_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, zero;
    logic        ir_load, alu_src, rf_we, pc_en, halted;
    logic [1:0]  alu_op, wb_sel, pc_sel, err_code;
    logic [2:0]  state;

    step_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    string tag = "reset";

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .dmem_ack (dmem_ack),
        .zero     (zero),
        .ir_load  (ir_load),
        .alu_op   (alu_op),
        .alu_src  (alu_src),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .pc_en    (pc_en),
        .pc_sel   (pc_sel),
        .state    (state),
        .halted   (halted),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    task automatic push(input logic rst_n, input logic ia, input logic da, input logic z,
                        input logic [31:0] ins, input exp_t e);
        step_t s;
        s.rst_n = rst_n; s.ia = ia; s.da = da; s.z = z; s.ins = ins; s.e = e;
        q.push_back(s);
    endtask

    task automatic push_halt(input int n, input logic [1:0] err, input logic ia, input logic da);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = blank(ST_HALT);
            e.halted = 1'b1;
            e.err_code = err;
            push(1'b1, ia, da, 1'b0, $urandom(), e);
        end
    endtask

    task automatic push_reset();
        push(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, blank(ST_FETCH));
    endtask

    // Reference trace for one instruction. iw/dw: wait cycles before the
    // imem/dmem ack; negative means the ack never comes.
    task automatic gen_instr(input logic [6:0] op, input int iw, input int dw, input logic z);
        exp_t e;
        logic [31:0] word;
        logic [1:0] aop;
        logic asrc, legal;
        aop = 2'b00; asrc = 1'b0; legal = 1'b1;
        case (op)
            OP_R:         aop = 2'b10;
            OP_I:         begin aop = 2'b10; asrc = 1'b1; end
            OP_LW, OP_SW: asrc = 1'b1;
            OP_BEQ:       aop = 2'b01;
            OP_JAL:       ;
            default:      legal = 1'b0;
        endcase
        word = $urandom();
        word[6:0] = op;
        if (iw < 0) begin
            for (int i = 0; i < TIMEOUT + 1; i++) begin
                e = blank(ST_FETCH);
                e.imem_req = 1'b1;
                push(1'b1, 1'b0, 1'b0, z, $urandom(), e);
            end
            push_halt(3, 2'b10, 1'b1, 1'b0);
            return;
        end
        for (int i = 0; i <= iw; i++) begin
            e = blank(ST_FETCH);
            e.imem_req = 1'b1;
            e.ir_load = (i == iw);
            push(1'b1, (i == iw), 1'b0, z, (i == iw) ? word : $urandom(), e);
        end
        push(1'b1, 1'b0, 1'b0, z, $urandom(), blank(ST_DECODE));
        if (!legal) begin
            push_halt(20, 2'b01, 1'b1, 1'b1);
            return;
        end
        e = blank(ST_EXEC);
        e.alu_op = aop;
        e.alu_src = asrc;
        if (op == OP_BEQ) begin
            e.pc_en = 1'b1;
            e.pc_sel = z ? 2'b01 : 2'b00;
        end
        push(1'b1, 1'b0, 1'b0, z, $urandom(), e);
        if (op == OP_LW || op == OP_SW) begin
            for (int j = 0; j <= ((dw < 0) ? TIMEOUT : dw); j++) begin
                e = blank(ST_MEM);
                e.alu_op = aop;
                e.alu_src = asrc;
                e.dmem_req = 1'b1;
                e.dmem_we = (op == OP_SW);
                e.pc_en = (op == OP_SW) && (dw >= 0) && (j == dw);
                push(1'b1, 1'b0, (dw >= 0) && (j == dw), z, $urandom(), e);
            end
            if (dw < 0) begin
                push_halt(3, 2'b11, 1'b0, 1'b1);
                return;
            end
        end
        if (op != OP_BEQ && op != OP_SW) begin
            e = blank(ST_WB);
            e.rf_we = 1'b1;
            e.wb_sel = (op == OP_LW) ? 2'b01 : ((op == OP_JAL) ? 2'b10 : 2'b00);
            e.pc_en = 1'b1;
            e.pc_sel = (op == OP_JAL) ? 2'b10 : 2'b00;
            push(1'b1, 1'b0, 1'b0, z, $urandom(), e);
        end
    endtask

    task automatic check(input exp_t e_in);
        exp_t o, e;
        e = e_in;
        o = '{state, imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src,
              rf_we, wb_sel, pc_en, pc_sel, halted, err_code};
        // ALU controls during write-back are left unconstrained.
        if (e.state == ST_WB) begin
            o.alu_op = 2'b00; o.alu_src = 1'b0;
            e.alu_op = 2'b00; e.alu_src = 1'b0;
        end
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s step %0d observed=%h expected=%h", tag, step_no, o, e);
        end
    endtask

    task automatic drain();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset    = s.rst_n;
            imem_ack = s.ia;
            dmem_ack = s.da;
            zero     = s.z;
            instr    = s.ins;
            #1;
            check(s.e);
            $display("step %0d %s state=%0d pc_en=%b rf_we=%b err=%0d", step_no, tag,
                     state, pc_en, rf_we, err_code);
            step_no++;
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; instr = '0;
        #2 reset = 1'b0;

        tag = "reset";     push_reset(); push_reset(); drain();
        tag = "r_add";     gen_instr(OP_R,   0, 0, 1'b0); drain();
        tag = "beq_taken"; gen_instr(OP_BEQ, 0, 0, 1'b1); drain();
        tag = "beq_nt";    gen_instr(OP_BEQ, 0, 0, 1'b0); drain();
        tag = "lw_wait3";  gen_instr(OP_LW,  0, 3, 1'b0); drain();
        tag = "sw_wait1";  gen_instr(OP_SW,  2, 1, 1'b0); drain();
        tag = "i_type";    gen_instr(OP_I,   0, 0, 1'b0); drain();
        tag = "jal";       gen_instr(OP_JAL, 1, 0, 1'b0); drain();
        tag = "sw_fast";   gen_instr(OP_SW,  0, 0, 1'b0); drain();
        tag = "lw_edge";   gen_instr(OP_LW, TIMEOUT, TIMEOUT, 1'b0); drain();

        tag = "illegal";   gen_instr(7'b0000000, 0, 0, 1'b0); drain();
        tag = "rst_ill";   push_reset(); drain();
        tag = "imem_to";   gen_instr(OP_R, -1, 0, 1'b0); drain();
        tag = "rst_imem";  push_reset(); drain();
        tag = "dmem_to";   gen_instr(OP_LW, 0, -1, 1'b0); drain();
        tag = "rst_dmem";  push_reset(); drain();

        tag = "mid_reset";
        gen_instr(OP_LW, 0, 5, 1'b0);
        while (q.size() > 5) q.delete(q.size() - 1);
        push_reset();
        drain();
        tag = "recover";   gen_instr(OP_R, 0, 0, 1'b0); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
